// File: rtl/read_channel_axi_mb.sv
// read_channel_axi_mb: cache line-refill read engine over an AXI4 read channel.
// A line is fetched as NBURST bursts of 2^BURST_W beats. A burst that ends in a
// slave error or is malformed is retried up to MAX_RETRY times. When the retries
// run out, replace_err pulses for one cycle.
// Optional build macro READ_CHANNEL_AXI_PERF_EN adds two saturating counters:
// perf_refills and perf_retries.
module read_channel_axi_mb #(
  parameter int FE_ADDR_W   = 32,
  parameter int FE_DATA_W   = 32,
  parameter int WORD_OFF_W  = 3,
  parameter int BE_ADDR_W   = FE_ADDR_W,
  parameter int BE_DATA_W   = FE_DATA_W,
  parameter int AXI_ID_W    = 1,
  parameter int AXI_ID      = 0,
  parameter int MAX_BURST_W = 8,
  parameter int MAX_RETRY   = 3,
  localparam int BE_BYTE_W  = $clog2(BE_DATA_W / 8),
  localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int BURST_W    = (LINE2MEM_W < MAX_BURST_W) ? LINE2MEM_W : MAX_BURST_W,
  localparam int NBURST     = 2 ** (LINE2MEM_W - BURST_W),
  localparam int RADDR_W    = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W,
  localparam int RA_W       = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 replace_valid,
  input  logic [RADDR_W-1:0]   replace_addr,
  output logic                 replace,
  output logic                 replace_err,
  output logic                 read_valid,
  output logic [RA_W-1:0]      read_addr,
  output logic [BE_DATA_W-1:0] read_rdata,
  output logic [AXI_ID_W-1:0]  m_axi_arid,
  output logic [BE_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]           m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic                 m_axi_arlock,
  output logic [3:0]           m_axi_arcache,
  output logic [2:0]           m_axi_arprot,
  output logic [3:0]           m_axi_arqos,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [AXI_ID_W-1:0]  m_axi_rid,
  input  logic [BE_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready
`ifdef READ_CHANNEL_AXI_PERF_EN
  ,
  output logic [31:0]          perf_refills,
  output logic [15:0]          perf_retries
`endif
);

  localparam int BEATS = 2 ** BURST_W;
  localparam int IDX_W = (LINE2MEM_W - BURST_W > 0) ? (LINE2MEM_W - BURST_W) : 1;
  localparam int BC_W  = BURST_W + 1;
  localparam int RC_W  = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, END = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] burst_idx;
  logic [BC_W-1:0]  beat_cnt;
  logic [RC_W-1:0]  retry_cnt;
  logic             err_flag;

  logic             accept;
  logic             at_max;
  logic             over;
  logic             beat_err;
  logic             last_burst;
  logic             can_retry;
  logic [RA_W-1:0]  burst_base;

  // beat_cnt is one bit wider than a burst needs. Once it reaches BEATS it marks
  // overrun beats that arrive after a missing rlast.
  assign accept     = (state == DATA) && m_axi_rvalid;
  assign at_max     = (beat_cnt == BC_W'(BEATS - 1));
  assign over       = (beat_cnt == BC_W'(BEATS));
  assign beat_err   = (m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID_W'(AXI_ID))
                   || (m_axi_rlast && !at_max) || (at_max && !m_axi_rlast);
  assign last_burst = (burst_idx == IDX_W'(NBURST - 1));
  assign can_retry  = (retry_cnt < RC_W'(MAX_RETRY));
  assign burst_base = RA_W'(RA_W'(burst_idx) << BURST_W);

  assign m_axi_arid    = AXI_ID_W'(AXI_ID);
  assign m_axi_araddr  = (BE_ADDR_W'(replace_addr) << (LINE2MEM_W + BE_BYTE_W))
                       | (BE_ADDR_W'(burst_idx) << (BURST_W + BE_BYTE_W));
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(BE_BYTE_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;

  assign read_valid = accept && !over;
  assign read_rdata = m_axi_rdata;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state selection and handshake/status outputs, all decoded from state.
  always_comb begin
    state_nxt     = state;
    replace       = 1'b0;
    replace_err   = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: if (replace_valid) state_nxt = ADDR;
      ADDR: begin
        replace       = 1'b1;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = DATA;
      end
      DATA: begin
        replace      = 1'b1;
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) state_nxt = END;
      end
      END: begin
        replace = 1'b1;
        if (!err_flag)     state_nxt = last_burst ? IDLE : ADDR;
        else if (can_retry) state_nxt = ADDR;
        else begin
          state_nxt   = IDLE;
          replace_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst and beat bookkeeping: burst index, beat count, retry count, sticky
  // error flag and the line RAM beat address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_idx <= '0;
      beat_cnt  <= '0;
      retry_cnt <= '0;
      err_flag  <= 1'b0;
      read_addr <= '0;
    end else begin
      case (state)
        IDLE: if (replace_valid) begin
          burst_idx <= '0;
          retry_cnt <= '0;
          err_flag  <= 1'b0;
        end
        ADDR: if (m_axi_arready) begin
          beat_cnt  <= '0;
          read_addr <= burst_base;
        end
        DATA: if (accept) begin
          if (!over) beat_cnt <= beat_cnt + BC_W'(1);
          if (beat_err) err_flag <= 1'b1;
          if ((beat_cnt < BC_W'(BEATS - 1)) && !m_axi_rlast) read_addr <= read_addr + RA_W'(1);
        end
        END: begin
          if (!err_flag) begin
            if (!last_burst) begin
              burst_idx <= burst_idx + IDX_W'(1);
              retry_cnt <= '0;
            end
          end else if (can_retry) begin
            retry_cnt <= retry_cnt + RC_W'(1);
            err_flag  <= 1'b0;
            read_addr <= burst_base;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef READ_CHANNEL_AXI_PERF_EN
  logic refill_done;
  logic retry_issue;

  assign refill_done = (state == END) && ((!err_flag && last_burst) || (err_flag && !can_retry));
  assign retry_issue = (state == END) && err_flag && can_retry;

  // Saturating counts of finished refills (good or abandoned) and of retries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_refills <= '0;
      perf_retries <= '0;
    end else begin
      if (refill_done && (perf_refills != '1)) perf_refills <= perf_refills + 32'd1;
      if (retry_issue && (perf_retries != '1)) perf_retries <= perf_retries + 16'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_read_channel_axi_mb.sv
// Bench for read_channel_axi_mb. The DUT is configured for 2 bursts of 4 beats
// per line, with 3 retries per burst. A reference model plans each refill as a
// list of slave responses. From that list it derives the expected AR addresses,
// the line RAM writes and the error pulse.
module tb_read_channel_axi_mb;

  localparam int MAXB  = 2;
  localparam int MAXR  = 3;
  localparam int BEATS = 4;   // 2^min(3, MAXB)
  localparam int NB    = 2;   // 8 words per line / 4 beats per burst

  // Slave response kinds: 0 clean, 1 SLVERR at beat k, 2 rlast early on beat k
  // (1-based count), 3 wrong rid at beat k, 4 k extra beats past the last one.
  typedef struct { int kind; int k; logic [31:0] dbase; } scen_t;
  typedef struct { logic [2:0] a; logic [31:0] d; } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        replace_valid;
  logic [26:0] replace_addr;
  logic        replace, replace_err, read_valid;
  logic [2:0]  read_addr;
  logic [31:0] read_rdata;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic        arlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  arcache, arqos;
  logic [0:0]  rid;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  scen_t       scen_q[$];
  scen_t       forced_q[$];
  logic [31:0] exp_ar[$];
  wr_t         exp_wr[$];
  int          exp_err;
  logic [31:0] got_ar[$];
  logic [7:0]  got_len[$];
  wr_t         got_wr[$];
  int          err_cycles;

  always #5 clk = ~clk;

  read_channel_axi_mb #(.MAX_BURST_W(MAXB), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset_n(reset_n),
    .replace_valid(replace_valid), .replace_addr(replace_addr),
    .replace(replace), .replace_err(replace_err),
    .read_valid(read_valid), .read_addr(read_addr), .read_rdata(read_rdata),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic scen_t pick();
    scen_t s;
    int r;
    s.dbase = $urandom;
    if (forced_q.size() > 0) begin
      scen_t f = forced_q.pop_front();
      s.kind = f.kind;
      s.k = f.k;
      return s;
    end
    r = $urandom_range(0, 9);
    s.kind = (r < 6) ? 0 : r - 5;
    case (s.kind)
      2:       s.k = $urandom_range(1, BEATS - 1);
      4:       s.k = $urandom_range(1, 3);
      default: s.k = $urandom_range(0, BEATS - 1);
    endcase
    return s;
  endfunction

  function automatic void force_kind(input int kind, input int k);
    scen_t s;
    s.kind = kind;
    s.k = k;
    s.dbase = '0;
    forced_q.push_back(s);
  endfunction

  // Reference model. For each burst, one attempt is made per slave response
  // until a clean one. After MAX_RETRY failed retries the refill is abandoned.
  task automatic plan(input logic [26:0] a);
    bit abandon = 0;
    exp_ar.delete();
    exp_wr.delete();
    exp_err = 0;
    for (int b = 0; b < NB && !abandon; b++) begin
      for (int att = 0; att <= MAXR; att++) begin
        scen_t s = pick();
        int nw = (s.kind == 2) ? s.k : BEATS;
        scen_q.push_back(s);
        exp_ar.push_back((32'(a) << 5) + 32'(b * BEATS * 4));
        for (int i = 0; i < nw; i++) begin
          wr_t w;
          w.a = 3'(b * BEATS + i);
          w.d = s.dbase + 32'(i);
          exp_wr.push_back(w);
        end
        if (s.kind == 0) break;
        if (att == MAXR) begin
          abandon = 1;
          exp_err = 1;
        end
      end
    end
  endtask

  // AXI slave and monitor. Inputs are driven on the falling edge. Outputs are
  // sampled 1 ns later, which gives the values the DUT commits on the next
  // rising edge.
  initial begin
    scen_t cur;
    int bi = 0;
    int nb = 0;
    bit active = 0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 0; arready = 0; rvalid = 0; rlast = 0; rresp = 0; rid = 0;
        #1;
      end else begin
        arready = arvalid && ($urandom_range(0, 2) != 0);
        if (active && bi < nb) begin
          rvalid = ($urandom_range(0, 3) != 0);
          rdata  = cur.dbase + 32'(bi);
          rresp  = (cur.kind == 1 && bi == cur.k) ? 2'b10 : 2'b00;
          rid    = (cur.kind == 3 && bi == cur.k) ? 1'b1 : 1'b0;
          rlast  = (bi == nb - 1);
        end else begin
          rvalid = 0; rlast = 0; rresp = 0; rid = 0;
        end
        #1;
        if (rvalid && rready) begin
          bi++;
          if (bi == nb) active = 0;
        end
        if (arvalid && arready) begin
          got_ar.push_back(araddr);
          got_len.push_back(arlen);
          if (scen_q.size() > 0) cur = scen_q.pop_front();
          else begin cur.kind = 0; cur.k = 0; cur.dbase = 32'hDEAD0000; end
          nb = (cur.kind == 2) ? cur.k : (cur.kind == 4) ? BEATS + cur.k : BEATS;
          bi = 0;
          active = 1;
        end
      end
      if (read_valid) begin
        wr_t w;
        w.a = read_addr;
        w.d = read_rdata;
        got_wr.push_back(w);
      end
      if (replace_err) err_cycles++;
    end
  end

  task automatic start(input logic [26:0] a, input string tag);
    int n = 0;
    got_ar.delete(); got_len.delete(); got_wr.delete(); err_cycles = 0;
    @(negedge clk);
    replace_addr = a;
    replace_valid = 1;
    do begin @(negedge clk); #2; n++; end while (!replace && n < 20);
    chk({tag, " busy"}, replace, 1'b1);
    replace_valid = 0;
  endtask

  task automatic refill(input logic [26:0] a, input string tag);
    int n = 0;
    plan(a);
    start(a, tag);
    while (replace && n < 3000) begin @(negedge clk); #2; n++; end
    chk({tag, " done"}, replace, 1'b0);
    chk({tag, " ar_count"}, got_ar.size(), exp_ar.size());
    for (int i = 0; i < got_ar.size() && i < exp_ar.size(); i++) begin
      chk($sformatf("%s araddr%0d", tag, i), got_ar[i], exp_ar[i]);
      chk($sformatf("%s arlen%0d", tag, i), got_len[i], 8'(BEATS - 1));
    end
    chk({tag, " wr_count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      chk($sformatf("%s wr%0d", tag, i), {got_wr[i].a, got_wr[i].d}, {exp_wr[i].a, exp_wr[i].d});
    chk({tag, " err_cycles"}, err_cycles, exp_err);
    chk({tag, " resp_left"}, scen_q.size(), 0);
  endtask

  initial begin
    int n;
    reset_n = 0;
    replace_valid = 0;
    replace_addr = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset outs", {replace, replace_err, arvalid, rready, read_valid, read_addr}, '0);
    reset_n = 1;

    // Check the constant AR fields while the first request is pending.
    force_kind(0, 0); force_kind(0, 0);
    plan(27'h1234567);
    start(27'h1234567, "const");
    chk("ar_const", {arvalid, arid, arsize, arburst, arlock, arcache, arprot, arqos},
        {1'b1, 1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    n = 0;
    while (replace && n < 3000) begin @(negedge clk); #2; n++; end
    chk("const done", replace, 1'b0);

    force_kind(0, 0); force_kind(0, 0);
    refill(27'h1234567, "clean");
    force_kind(1, 2); force_kind(0, 0); force_kind(0, 0);
    refill(27'h0ABCDEF, "slverr_once");
    for (int i = 0; i <= MAXR; i++) force_kind(1, i % BEATS);
    refill(27'h7FFFFFF, "slverr_all");
    force_kind(2, 3); force_kind(0, 0); force_kind(0, 0);
    refill(27'h0000001, "early_last");
    force_kind(0, 0); force_kind(4, 1); force_kind(0, 0);
    refill(27'h2468ACE, "late_last");

    for (int t = 0; t < 20; t++) refill(27'($urandom), $sformatf("rand%0d", t));

    // Reset in the middle of a data burst.
    force_kind(0, 0); force_kind(0, 0);
    plan(27'h0555555);
    start(27'h0555555, "rst_mid");
    n = 0;
    while (got_wr.size() < 3 && n < 200) begin @(negedge clk); #2; n++; end
    chk("rst_mid beats", got_wr.size() >= 3, 1'b1);
    reset_n = 0;
    #1;
    chk("rst_mid outs", {arvalid, rready, replace, read_valid, replace_err}, '0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1;
    scen_q.delete();
    force_kind(0, 0); force_kind(0, 0);
    refill(27'h0555555, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
